pmmu_arbiter: RTL

//  Shares the single Pmmu port between the instruction-fetch requester (ControlMatrix fetch path)
//  and the load/store data requester. Arbitrates, latches the winning request, holds Pmmu strobes

---
 rtl/pmmu_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pmmu_arbiter.sv
// pmmu_arbiter: shares the single Pmmu port between the fetch and load/store requesters.
// Define PMMU_ARB_RR_EN to replace the fixed data-first tie-break with round-robin.
module pmmu_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  f_req_i,
    input  logic [ADDR_WIDTH-1:0] f_addr_i,
    output logic                  f_gnt_o,
    output logic                  f_rdy_o,
    input  logic                  d_req_i,
    input  logic                  d_wr_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wd_i,
    input  logic [2:0]            d_funct3_i,
    output logic                  d_gnt_o,
    output logic                  d_rdy_o,
    output logic [DATA_WIDTH-1:0] rd_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    output logic [2:0]            mem_funct3_o,
    output logic                  mem_wr_o,
    output logic                  mem_rd_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i,
    input  logic                  mem_rdy_i
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_RESP   = 2'b10;

    localparam logic       OWN_FETCH   = 1'b0;
    localparam logic       OWN_DATA    = 1'b1;
    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    logic [1:0]            state_q, state_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  f_gnt_q, f_gnt_d;
    logic                  d_gnt_q, d_gnt_d;
    logic                  f_rdy_q, f_rdy_d;
    logic                  d_rdy_q, d_rdy_d;
    logic                  busy_q, busy_d;
    logic                  pick_data_c;
    logic                  accept_c;

    assign accept_c = (state_q == ST_IDLE) && (f_req_i || d_req_i);

`ifdef PMMU_ARB_RR_EN
    logic last_owner_q;

    // On a tie, serve whichever port was not served last
    assign pick_data_c = d_req_i && (!f_req_i || (last_owner_q == OWN_FETCH));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_owner_q <= OWN_DATA;
        end else if (accept_c) begin
            last_owner_q <= pick_data_c ? OWN_DATA : OWN_FETCH;
        end
    end
`else
    assign pick_data_c = d_req_i;
`endif

    // Next-state and registered-output decode
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wd_d     = wd_q;
        rd_d     = rd_q;
        funct3_d = funct3_q;
        mem_rd_d = mem_rd_q;
        mem_wr_d = mem_wr_q;
        f_gnt_d  = 1'b0;
        d_gnt_d  = 1'b0;
        f_rdy_d  = 1'b0;
        d_rdy_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_ACCESS;
                    if (pick_data_c) begin
                        owner_d  = OWN_DATA;
                        addr_d   = d_addr_i;
                        wd_d     = d_wd_i;
                        funct3_d = d_funct3_i;
                        mem_wr_d = d_wr_i;
                        mem_rd_d = !d_wr_i;
                        d_gnt_d  = 1'b1;
                    end else begin
                        owner_d  = OWN_FETCH;
                        addr_d   = f_addr_i;
                        wd_d     = '0;
                        funct3_d = FUNCT3_WORD;
                        mem_wr_d = 1'b0;
                        mem_rd_d = 1'b1;
                        f_gnt_d  = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_rdy_i) begin
                    state_d  = ST_RESP;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (mem_rd_q) begin
                        rd_d = mem_rd_i;
                    end
                    if (owner_q == OWN_DATA) begin
                        d_rdy_d = 1'b1;
                    end else begin
                        f_rdy_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_FETCH;
            addr_q   <= '0;
            wd_q     <= '0;
            rd_q     <= '0;
            funct3_q <= '0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            f_gnt_q  <= 1'b0;
            d_gnt_q  <= 1'b0;
            f_rdy_q  <= 1'b0;
            d_rdy_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            rd_q     <= rd_d;
            funct3_q <= funct3_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            f_gnt_q  <= f_gnt_d;
            d_gnt_q  <= d_gnt_d;
            f_rdy_q  <= f_rdy_d;
            d_rdy_q  <= d_rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign f_gnt_o      = f_gnt_q;
    assign d_gnt_o      = d_gnt_q;
    assign f_rdy_o      = f_rdy_q;
    assign d_rdy_o      = d_rdy_q;
    assign rd_o         = rd_q;
    assign busy_o       = busy_q;
    assign mem_addr_o   = addr_q;
    assign mem_wd_o     = wd_q;
    assign mem_funct3_o = funct3_q;
    assign mem_rd_o     = mem_rd_q;
    assign mem_wr_o     = mem_wr_q;

endmodule
